uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped 8N1 UART transmitter on the CPU data bus.
- Sits beside the RAM and the LED register in the SoC and consumes CPU data-bus writes.
- Buffers bytes in a small FIFO and serialises them onto a tx pin.
- Returns a registered status word on the bus read path with the same 1-cycle latency as the RAM.

Parameters:
- BASE_ADDR, 32'h2000_0010, word address of TXDATA; STATUS is at BASE_ADDR+4.
- CLK_DIV, 104, clock cycles per UART bit (range 2..65535).
- FIFO_DEPTH, 8, TX FIFO entries (power of two, 2..64).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- data_addr  in  32  CPU data address.
- data_wr  in  32  CPU write data.
- data_wr_en  in  4  byte-lane write enables.
- data_rd  out  32  registered read data; valid 1 cycle after the address is presented.
- tx  out  1  UART serial output, idle high.
- tx_busy  out  1  high while a frame is on the wire or the FIFO is non-empty.

Behaviour:
- Reset (async, resetn=0):
  - tx=1, data_rd=0, tx_busy=0.
  - FIFO empty, overflow flag=0, FSM=IDLE, baud counter=0.
  - A reset asserted mid-frame forces tx=1 immediately and discards the FIFO contents.
- TXDATA write:
  - Condition: data_addr==BASE_ADDR and data_wr_en[0]=1.
  - Pushes data_wr[7:0]. Other lanes are ignored.
  - Writes with data_wr_en[0]=0 have no effect.
- Push acceptance:
  - Accepted if FIFO count<FIFO_DEPTH, or a pop occurs in the same cycle (full + simultaneous pop → accepted, count unchanged).
  - Otherwise the byte is dropped and overflow is set (sticky).
- STATUS write:
  - Condition: data_addr==BASE_ADDR+4 and data_wr_en[0]=1.
  - data_wr[3]=1 clears overflow (W1C). Other bits are ignored.
  - A clear and a new overflow in the same cycle → overflow stays 1.
- Read path: every cycle, data_rd is registered as follows.
  - STATUS when data_addr==BASE_ADDR+4.
  - 0 for TXDATA or any other address.
  - No read strobe exists; reads have no side effects.
- STATUS layout:
  - [0] tx_busy, [1] fifo_full, [2] fifo_empty, [3] overflow.
  - [10:4] fifo_count, zero-extended. All other bits 0.
  - Values are sampled in the same cycle as the address.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop into shift register, set baud counter=CLK_DIV-1, bit index=0, go to START.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLK_DIV cycles; shift right at the end of each bit; after bit 7 go to STOP.
  - STOP: tx=1 for CLK_DIV cycles, then go to IDLE.
- Frame timing:
  - Frame = 10*CLK_DIV cycles.
  - Back-to-back frames are separated by exactly 1 IDLE cycle.
  - First start-bit edge appears on tx 2 cycles after the accepted write: 1 cycle to FIFO, 1 cycle IDLE pop.
- Baud counter:
  - Decrements each cycle; at 0 the bit ends and the counter reloads CLK_DIV-1.
  - Width is $clog2(CLK_DIV).
- FIFO pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
- tx_busy = (state!=IDLE) | !fifo_empty.
- tx is driven from a flop (glitch-free).

Decomposition:
- soc_pkg:
  - UART register offset constants (TXDATA=0, STATUS=4).
  - STATUS bit index constants.
  - FSM state typedef (2-bit enum).
- Sub-module sync_fifo:
  - Parameters: WIDTH=8, DEPTH=FIFO_DEPTH.
  - Ports: push, pop, din, dout, full, empty, count; same clk/resetn.
  - Implements the full-with-simultaneous-pop rule.
- uart_tx_mmio holds the bus decode, the status register and the FSM.

Test Plan:
- Single byte: CLK_DIV=4, write 0x55 to TXDATA → tx low 4 cycles starting 2 cycles later, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, high 4 cycles; total 40 cycles; tx_busy falls after the stop bit.
- Status read: FIFO empty, idle → read STATUS returns 32'h0000_0004 on the next cycle; reading TXDATA returns 0.
- Overflow: CLK_DIV=1000, FIFO_DEPTH=8; write 10 bytes back-to-back.
  - First byte popped → 9 accepted, 1 dropped.
  - STATUS shows count=8, full=1, overflow=1.
  - Write STATUS 0x8 → overflow=0, count unchanged.
- Back-to-back: write 0xA5 then 0x3C in consecutive cycles, CLK_DIV=4 → two 40-cycle frames separated by exactly 1 idle-high cycle; bytes LSB first.
- Byte-lane gating: write TXDATA with data_wr_en=4'b0010 → no push; fifo_empty stays 1; tx stays high.
- Reset mid-frame: assert resetn=0 during DATA bit 3 → tx=1 asynchronously. After release: STATUS=32'h0000_0004 and no residual frame is transmitted.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared SoC constants: UART register offsets, STATUS bit positions and the
// transmitter FSM state type.
package soc_pkg;

  localparam logic [31:0] TxdataOffset = 32'h0000_0000;
  localparam logic [31:0] StatusOffset = 32'h0000_0004;

  localparam int unsigned StatBusy   = 0;
  localparam int unsigned StatFull   = 1;
  localparam int unsigned StatEmpty  = 2;
  localparam int unsigned StatOvf    = 3;
  localparam int unsigned StatCntLsb = 4;
  localparam int unsigned StatCntMsb = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW:0]   CntOne = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH[PtrW:0]);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS is
// read back through a registered path, and an FSM serialises bytes onto tx.
module uart_tx_mmio
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0010,
  parameter int unsigned CLK_DIV    = 104,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wr_en,
  output logic [31:0] data_rd,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned CntW  = $clog2(CLK_DIV);
  localparam int unsigned FillW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] BaudReload = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntOne     = 1;

  logic             txdata_sel, status_sel, wr_txdata, wr_status;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [FillW-1:0] fifo_count;
  logic             ovf_q, ovf_d;
  logic [31:0]      status, rd_q, rd_d;

  uart_state_e      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  logic unused_bits;
  assign unused_bits = ^data_wr_en[3:1];

  assign txdata_sel = (data_addr == BASE_ADDR + TxdataOffset);
  assign status_sel = (data_addr == BASE_ADDR + StatusOffset);
  assign wr_txdata  = txdata_sel & data_wr_en[0];
  assign wr_status  = status_sel & data_wr_en[0];
  assign fifo_pop   = (state_q == StIdle) & ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr_txdata),
    .pop    (fifo_pop),
    .din    (data_wr[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // A dropped byte wins over a simultaneous W1C clear.
  assign ovf_d = (ovf_q & ~(wr_status & data_wr[StatOvf])) |
                 (wr_txdata & fifo_full & ~fifo_pop);

  assign tx_busy = (state_q != StIdle) | ~fifo_empty;

  always_comb begin
    status                        = '0;
    status[StatBusy]              = tx_busy;
    status[StatFull]              = fifo_full;
    status[StatEmpty]             = fifo_empty;
    status[StatOvf]               = ovf_q;
    status[StatCntMsb:StatCntLsb] = 7'(fifo_count);
    rd_d                          = status_sel ? status : 32'h0;
  end

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != StIdle) cnt_d = bit_end ? BaudReload : cnt_q - CntOne;
    // tx_d carries the level of the state being entered so tx stays a flop.
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shift_d = fifo_dout;
          cnt_d   = BaudReload;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d  = shift_q[1];
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end

  assign tx      = tx_q;
  assign data_rd = rd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a frame-level model (byte queue plus
// remaining-frame-time counter) is compared against the DUT every cycle.
module tb_uart_tx_mmio;

  localparam logic [31:0] Base     = 32'h2000_0010;
  localparam int          Div      = 4;
  localparam int          Depth    = 8;
  localparam int          FrameLen = 10 * Div;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wr = '0;
  logic [3:0]  data_wr_en = '0;
  logic [31:0] data_rd;
  logic        tx, tx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .BASE_ADDR  (Base),
    .CLK_DIV    (Div),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .data_addr  (data_addr),
    .data_wr    (data_wr),
    .data_wr_en (data_wr_en),
    .data_rd    (data_rd),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes waiting, byte on the wire, cycles of that frame remaining.
  logic [7:0]  m_fifo[$];
  logic [7:0]  m_byte = '0;
  int          m_rem = 0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_rd = '0;

  function automatic logic m_tx();
    int idx;
    if (m_rem == 0) return 1'b1;
    idx = (FrameLen - m_rem) / Div;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  function automatic logic m_busy();
    return (m_rem != 0) || (m_fifo.size() != 0);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = m_busy();
    s[1]    = (m_fifo.size() == Depth);
    s[2]    = (m_fifo.size() == 0);
    s[3]    = m_ovf;
    s[10:4] = 7'(m_fifo.size());
    return s;
  endfunction

  initial forever begin
    logic pop, wt, ws, drop;
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_fifo.delete();
      m_rem = 0;
      m_ovf = 1'b0;
      m_rd  = '0;
    end else begin
      m_rd = (data_addr == Base + 4) ? m_status() : 32'h0;
      pop  = (m_rem == 0) && (m_fifo.size() != 0);
      wt   = (data_addr == Base) && data_wr_en[0];
      ws   = (data_addr == Base + 4) && data_wr_en[0];
      if (pop) begin
        m_byte = m_fifo.pop_front();
        m_rem  = FrameLen;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      drop = 1'b0;
      if (wt) begin
        if (m_fifo.size() < Depth) m_fifo.push_back(data_wr[7:0]);
        else drop = 1'b1;
      end
      m_ovf = (m_ovf && !(ws && data_wr[3])) || drop;
    end
  end

  initial forever begin
    @(negedge clk);
    if (resetn) begin
      check("tx", {31'b0, tx}, {31'b0, m_tx()});
      check("tx_busy", {31'b0, tx_busy}, {31'b0, m_busy()});
      check("data_rd", data_rd, m_rd);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
    @(posedge clk);
    #2;
    data_addr  = a;
    data_wr    = d;
    data_wr_en = en;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(32'h0, 32'h0, 4'h0);
  endtask

  task automatic read_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 32'h0, 4'h0);
    drive(32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check(name, data_rd, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_rem != 0 || m_fifo.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", n, 0);
    idle(2);
  endtask

  logic cap_tx   [0:99];
  logic cap_busy [0:99];

  task automatic capture(input int n);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap_tx[k]   = tx;
      cap_busy[k] = tx_busy;
    end
  endtask

  initial begin
    int n;
    int lows;
    logic [31:0] a;
    int r;

    idle(3);
    @(negedge clk);
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_busy", {31'b0, tx_busy}, 32'h0);
    check("reset_rd", data_rd, 32'h0);
    @(posedge clk);
    #2 resetn = 1'b1;

    read_reg("status_idle", Base + 4, 32'h0000_0004);
    read_reg("txdata_read", Base, 32'h0);

    // Single byte 0x55
    fork
      begin
        drive(Base, 32'h55, 4'h1);
        drive(32'h0, 32'h0, 4'h0);
      end
      capture(45);
    join
    check("single_busy_k0", {31'b0, cap_busy[0]}, 32'h0);
    check("single_tx_k1", {31'b0, cap_tx[1]}, 32'h1);
    check("single_start_k2", {31'b0, cap_tx[2]}, 32'h0);
    check("single_start_k5", {31'b0, cap_tx[5]}, 32'h0);
    check("single_bit0", {31'b0, cap_tx[6]}, 32'h1);
    check("single_bit1", {31'b0, cap_tx[10]}, 32'h0);
    check("single_bit7", {31'b0, cap_tx[37]}, 32'h0);
    check("single_stop", {31'b0, cap_tx[38]}, 32'h1);
    check("single_busy_k1", {31'b0, cap_busy[1]}, 32'h1);
    check("single_busy_k41", {31'b0, cap_busy[41]}, 32'h1);
    check("single_busy_k42", {31'b0, cap_busy[42]}, 32'h0);
    wait_idle();

    // Back-to-back 0xA5, 0x3C
    fork
      begin
        drive(Base, 32'hA5, 4'h1);
        drive(Base, 32'h3C, 4'h1);
        drive(32'h0, 32'h0, 4'h0);
      end
      capture(90);
    join
    check("b2b_start1", {31'b0, cap_tx[2]}, 32'h0);
    check("b2b_a5_bit0", {31'b0, cap_tx[6]}, 32'h1);
    check("b2b_stop1", {31'b0, cap_tx[41]}, 32'h1);
    check("b2b_gap", {31'b0, cap_tx[42]}, 32'h1);
    check("b2b_start2", {31'b0, cap_tx[43]}, 32'h0);
    check("b2b_3c_bit0", {31'b0, cap_tx[47]}, 32'h0);
    check("b2b_3c_bit1", {31'b0, cap_tx[51]}, 32'h0);
    check("b2b_3c_bit2", {31'b0, cap_tx[55]}, 32'h1);
    wait_idle();

    // Overflow: 10 writes, first is popped, 9 accepted, last dropped
    for (int i = 0; i < 10; i++) drive(Base, 32'(i + 8'h30), 4'h1);
    read_reg("ovf_status", Base + 4, 32'h0000_008B);
    drive(Base + 4, 32'h8, 4'h1);
    read_reg("ovf_cleared", Base + 4, 32'h0000_0083);
    wait_idle();

    // Byte-lane gating
    drive(Base, 32'h77, 4'b0010);
    read_reg("lane_gated", Base + 4, 32'h0000_0004);
    @(negedge clk);
    check("lane_tx_high", {31'b0, tx}, 32'h1);

    // Reset during DATA bit 3 of 0xF0 (that bit is 0)
    drive(Base, 32'hF0, 4'h1);
    drive(Base, 32'h81, 4'h1);
    drive(32'h0, 32'h0, 4'h0);
    n = 0;
    while (!(m_rem != 0 && (FrameLen - m_rem) / Div == 4) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("midframe_timeout", n, 0);
    #1;
    check("pre_reset_tx", {31'b0, tx}, 32'h0);
    resetn = 1'b0;
    #1;
    check("async_reset_tx", {31'b0, tx}, 32'h1);
    check("async_reset_busy", {31'b0, tx_busy}, 32'h0);
    check("async_reset_rd", data_rd, 32'h0);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    read_reg("status_after_reset", Base + 4, 32'h0000_0004);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("no_residual_frame", lows, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      a = Base;
      else if (r < 8) a = Base + 4;
      else            a = $urandom;
      drive(a, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
